muldiv_ctrl: RTL and testbench

Iterative multiply/divide controller for the EXE stage. It accepts MULT/MULTU/DIV/DIVU from EXE and sequences a radix-2 shift-add multiplier and a restoring divider that it owns. It holds EXE with `busy` until the result is ready, and owns the architectural HI/LO registers, including MTHI/MTLO writes. A pipeline flush cancels an in-flight operation without touching HI/LO.

---
 rtl/muldiv_ctrl.sv | 119 +++++++++++
 tb/tb_muldiv_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers.
// Ports: clk, reset (async, active-high); start/op/src1/src2 issue an operation from EXE;
// flush cancels an in-flight operation; mthi/mtlo/wdata write HI/LO directly;
// busy stalls EXE, done pulses for one cycle on completion, hi/lo are the architectural registers.
module muldiv_ctrl #(
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] dvs_q, dvs_d;
  logic        div_q, div_d, neg_q, neg_d, rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        sgn, dz;
  logic [31:0] m1, m2, quo, rem;
  logic [32:0] sum, shl, trial;
  logic [63:0] step, res;
  always_comb begin
    sgn   = ~op[0];
    dz    = op[1] & (src2 == 32'd0);
    // a zero divisor keeps the raw dividend with no sign fix-up: restoring steps
    // against 0 then shift the dividend into the remainder and set every quotient bit
    m1    = (sgn & src1[31] & ~dz) ? -src1 : src1;
    m2    = (sgn & src2[31]) ? -src2 : src2;
    // multiply: acc = {partial product, remaining multiplier bits}
    sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);
    // divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}
    shl   = acc_q[63:31];
    trial = shl - {1'b0, dvs_q};
    step  = div_q ? (trial[32] ? {shl[31:0], acc_q[30:0], 1'b0} : {trial[31:0], acc_q[30:0], 1'b1})
                  : {sum, acc_q[31:1]};
    quo   = neg_q ? -step[31:0] : step[31:0];
    rem   = rneg_q ? -step[63:32] : step[63:32];
    res   = div_q ? {rem, quo} : (neg_q ? -step : step);
    busy  = ~reset & ((state_q == BUSY) | (start & ~flush & (state_q != BUSY) & ~(FAST_ZERO & dz)));
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == BUSY) begin
      if (flush) begin
        state_d = IDLE;
      end else begin
        acc_d = step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d      = DONE;
          {hi_d, lo_d} = res;
        end
      end
    end else begin
      state_d = IDLE;
      hi_d    = mthi ? wdata : hi_q;
      lo_d    = mtlo ? wdata : lo_q;
      if (start & ~flush) begin
        if (FAST_ZERO && dz) begin
          state_d = DONE;
          hi_d    = src1;
          lo_d    = 32'hFFFF_FFFF;
        end else begin
          state_d = BUSY;
          cnt_d   = 6'd0;
          acc_d   = {32'd0, op[1] ? m1 : m2};
          dvs_d   = op[1] ? m2 : m1;
          div_d   = op[1];
          neg_d   = sgn & (src1[31] ^ src2[31]) & ~dz;
          rneg_d  = sgn & op[1] & src1[31] & ~dz;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized check of muldiv_ctrl (FAST_ZERO=1 as u0, FAST_ZERO=0 as u1) against an arithmetic model.
module tb_muldiv_ctrl;
  logic        clk, reset, start, flush, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] src1, src2, wdata;
  logic        busy0, done0, busy1, done1;
  logic [31:0] hi0, lo0, hi1, lo1;
  logic [31:0] exp_hi, exp_lo;
  int checks = 0, fails = 0;
  muldiv_ctrl #(.FAST_ZERO(1'b1)) u0 (.clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy0), .done(done0), .hi(hi0), .lo(lo0));
  muldiv_ctrl #(.FAST_ZERO(1'b0)) u1 (.clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // {HI, LO} from plain arithmetic; 64-bit signed division covers 0x80000000 / -1
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
    case (o)
      2'd0:    return 64'(sa * sb);
      2'd1:    return {32'd0, a} * {32'd0, b};
      2'd2:    return {32'(sa % sb), 32'(sa / sb)};
      default: return {a % b, a / b};
    endcase
  endfunction
  // called just after a negedge; returns at the negedge of cycle 33
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic ml, input logic [31:0] wd);
    logic [63:0] e;
    int l0, err;
    e  = model(o, a, b);
    l0 = (o[1] && b == 32'd0) ? 1 : 33;
    start = 1'b1; op = o; src1 = a; src2 = b; mtlo = ml; wdata = wd;
    #1;
    chk("busy_c0_fz", busy0, l0 == 33);
    chk("busy_c0", busy1, 1);
    @(posedge clk);
    #1;
    start = 1'b0; mtlo = 1'b0; src1 = $urandom; src2 = $urandom; op = 2'($urandom_range(0, 3));
    err = 0;
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      if (n == 1 && ml && l0 == 33) chk("mtlo_with_start", lo1, wd);
      if (busy0 !== (n < l0) || done0 !== (n == l0)) err++;
      if (busy1 !== (n < 33) || done1 !== (n == 33)) err++;
      if (n == l0) begin
        chk("hi_fz", hi0, e[63:32]);
        chk("lo_fz", lo0, e[31:0]);
      end
    end
    chk("busy_done_seq", err, 0);
    chk("hi", hi1, e[63:32]);
    chk("lo", lo1, e[31:0]);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
  endtask
  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; src1 = '0; src2 = '0; wdata = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_hi", hi1, 0);
    chk("rst_lo", lo1, 0);
    chk("rst_busy_done", {busy0, done0, busy1, done1}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    do_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, '0);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, '0);
    do_op(2'd3, 32'd7, 32'd2, 1'b0, '0);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0);
    do_op(2'd3, 32'h1234, 32'd0, 1'b0, '0);
    do_op(2'd2, 32'hFFFF_FF00, 32'd0, 1'b0, '0);
    // MTHI in idle
    @(negedge clk);
    mthi = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #1 mthi = 1'b0;
    @(negedge clk);
    chk("mthi_fz", hi0, 32'hA5A5_A5A5);
    chk("mthi", hi1, 32'hA5A5_A5A5);
    exp_hi = 32'hA5A5_A5A5;
    // flush in cycle 10, restart in cycle 12
    start = 1'b1; op = 2'd1; src1 = $urandom; src2 = $urandom;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {busy0, busy1}, 0);
    chk("flush_done", {done0, done1}, 0);
    chk("flush_hilo", {hi1, lo1}, {exp_hi, exp_lo});
    @(negedge clk);
    chk("flush_done_c12", done1, 0);
    do_op(2'd1, 32'd123456, 32'd789, 1'b0, '0);
    // MTLO ignored while busy
    @(negedge clk);
    start = 1'b1; op = 2'd0; src1 = $urandom; src2 = $urandom;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    mtlo = 1'b1; wdata = 32'h1;
    @(posedge clk);
    #1 mtlo = 1'b0;
    @(negedge clk);
    chk("mtlo_busy", lo1, exp_lo);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    // start together with flush is dropped
    start = 1'b1; flush = 1'b1; op = 2'd3; src1 = 32'd9; src2 = 32'd0;
    #1 chk("start_flush_busy", {busy0, busy1}, 0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("start_flush_idle", {busy0, done0, busy1, done1}, 0);
    do_op(2'd0, 32'd6, 32'hFFFF_FFFE, 1'b1, 32'h5555_0000);
    // asynchronous reset mid-operation
    start = 1'b1; op = 2'd1; src1 = $urandom; src2 = $urandom;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_hilo", {hi1, lo1}, 0);
    chk("midrst_busy_done", {busy0, done0, busy1, done1}, 0);
    start = 1'b1;
    #1 chk("rst_forces_busy0", {busy0, busy1}, 0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(2'd3, 32'd100, 32'd7, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      do_op(2'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)), $urandom);
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
